// File: rtl/note_hit_scorer.sv
// Rhythm-game hit scorer: per-lane hit/miss judgement FSMs feeding a shared
// score/combo accumulator with a combo-driven multiplier (1..4).

// Per-lane judgement FSM with registered one-cycle hit/miss pulses.
module note_hit_lane (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic in_zone,
  input  logic key_edge,
  output logic hit,
  output logic miss
);

  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;
  state_t state;

  // Judge each note once: a hit ends in DONE until the note leaves the zone.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      state <= IDLE;
      hit   <= 1'b0;
      miss  <= 1'b0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      case (state)
        IDLE: begin
          if (in_zone && key_edge) begin
            hit   <= 1'b1;
            state <= DONE;
          end else if (in_zone) begin
            state <= ARMED;
          end else if (key_edge) begin
            miss  <= 1'b1;          // ghost press
          end
        end
        ARMED: begin
          if (key_edge) begin
            hit   <= 1'b1;
            state <= DONE;
          end else if (!in_zone) begin
            miss  <= 1'b1;          // note left the zone unplayed
            state <= IDLE;
          end
        end
        DONE: begin
          if (!in_zone) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

module note_hit_scorer #(
  parameter int LANES      = 4,
  parameter int HIT_POINTS = 10,
  parameter int SCORE_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [LANES-1:0]   in_zone,
  input  logic [LANES-1:0]   key_down,
  output logic [LANES-1:0]   hit_pulse,
  output logic [LANES-1:0]   miss_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         combo,
  output logic [2:0]         multiplier
);

  localparam int NW = $clog2(LANES + 1);
  localparam int AW = SCORE_W + 16;
  localparam logic [AW-1:0] SCORE_MAX = {{(AW-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

  logic [LANES-1:0] key_q;
  logic [LANES-1:0] key_edge;
  logic [NW-1:0]    n_hits;
  logic [AW-1:0]    inc;
  logic [AW-1:0]    sum;
  logic [SCORE_W-1:0] score_next;
  logic [8:0]       combo_sum;

  // key_q resets to ones so keys held through reset never look like a press;
  // it keeps tracking while paused so a held key cannot fire when run rises.
  always_ff @(posedge clk) begin
    if (reset) key_q <= '1;
    else       key_q <= key_down;
  end

  assign key_edge = key_down & ~key_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    note_hit_lane u_lane (
      .clk      (clk),
      .reset    (reset),
      .run      (run),
      .in_zone  (in_zone[i]),
      .key_edge (key_edge[i]),
      .hit      (hit_pulse[i]),
      .miss     (miss_pulse[i])
    );
  end

  // Count lanes hitting this cycle.
  always_comb begin
    n_hits = '0;
    for (int i = 0; i < LANES; i++) n_hits = n_hits + NW'(hit_pulse[i]);
  end

  // Multiplier steps every 8 combo, capped at 4 once combo reaches 24.
  always_comb begin
    if (combo >= 8'd24) multiplier = 3'd4;
    else                multiplier = {1'b0, combo[4:3]} + 3'd1;
  end

  // Saturating score and combo next values, using the pre-update multiplier.
  always_comb begin
    inc        = AW'(HIT_POINTS) * AW'(multiplier) * AW'(n_hits);
    sum        = AW'(score) + inc;
    score_next = (sum > SCORE_MAX) ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    combo_sum  = {1'b0, combo} + 9'(n_hits);
  end

  // Accumulate on the edge after the pulses; any miss breaks the combo.
  always_ff @(posedge clk) begin
    if (reset) begin
      score <= '0;
      combo <= '0;
    end else if (run) begin
      score <= score_next;
      if (|miss_pulse)      combo <= 8'd0;
      else if (combo_sum[8]) combo <= 8'hFF;
      else                  combo <= combo_sum[7:0];
    end
  end

endmodule

// File: tb/tb_note_hit_scorer.sv
// Directed bench for note_hit_scorer: cycle table for single-lane hit/miss
// behaviour plus hand sequences for combo, multiplier, pause, reset, saturation.
module tb_note_hit_scorer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [3:0]  in_zone;
  logic [3:0]  key_down;
  logic [3:0]  hit_pulse;
  logic [3:0]  miss_pulse;
  logic [15:0] score;
  logic [7:0]  combo;
  logic [2:0]  multiplier;

  int total = 0;
  int bad   = 0;

  note_hit_scorer #(.LANES(4), .HIT_POINTS(10), .SCORE_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .in_zone    (in_zone),
    .key_down   (key_down),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .score      (score),
    .combo      (combo),
    .multiplier (multiplier)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] zone;
    logic [3:0] key;
    logic [3:0] hit;
    logic [3:0] miss;
    int         sc;
    int         cb;
  } vec_t;

  vec_t tbl[21];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; in_zone = '0; key_down = '0;
    step();
    reset = 1'b0;
    step();
  endtask

  // One clean hit on a lane: arm, press, release; leaves score updated.
  task automatic do_hit(input int lane);
    in_zone[lane] = 1'b1;
    step();
    key_down[lane] = 1'b1;
    step();
    chk("do_hit pulse", int'(hit_pulse), 1 << lane);
    in_zone = '0; key_down = '0;
    step();
  endtask

  int exp_s, exp_c, exp_m;

  initial begin
    // Cycle table: lane0 hit, lane2 pass-through miss, lane3 ghost press,
    // lane1 same-cycle zone+press hit and an ignored re-press in DONE.
    tbl[0]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0};
    tbl[1]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0};
    tbl[2]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0};
    tbl[3]  = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 0, 0};
    tbl[4]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 10, 1};
    tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 10, 1};
    tbl[6]  = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 10, 1};
    tbl[7]  = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 10, 1};
    tbl[8]  = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 10, 1};
    tbl[9]  = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 10, 1};
    tbl[10] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 10, 1};
    tbl[11] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 10, 1};
    tbl[12] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 10, 0};
    tbl[13] = '{4'b0000, 4'b1000, 4'b0000, 4'b1000, 10, 0};
    tbl[14] = '{4'b0000, 4'b1000, 4'b0000, 4'b0000, 10, 0};
    tbl[15] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 10, 0};
    tbl[16] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 10, 0};
    tbl[17] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 20, 1};
    tbl[18] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 20, 1};
    tbl[19] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 20, 1};
    tbl[20] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 20, 1};

    reset = 1'b1; run = 1'b0; in_zone = '0; key_down = '0;
    step(); step();
    chk("rst hit", int'(hit_pulse), 0);
    chk("rst miss", int'(miss_pulse), 0);
    chk("rst score", int'(score), 0);
    chk("rst combo", int'(combo), 0);
    chk("rst mult", int'(multiplier), 1);
    reset = 1'b0; run = 1'b1;
    step();

    for (int r = 0; r < 21; r++) begin
      in_zone = tbl[r].zone; key_down = tbl[r].key;
      step();
      chk($sformatf("tbl%0d hit", r), int'(hit_pulse), int'(tbl[r].hit));
      chk($sformatf("tbl%0d miss", r), int'(miss_pulse), int'(tbl[r].miss));
      chk($sformatf("tbl%0d score", r), int'(score), tbl[r].sc);
      chk($sformatf("tbl%0d combo", r), int'(combo), tbl[r].cb);
    end

    // Pause while a hit pulse is pending: pulse dropped, score/combo held.
    in_zone = 4'b0001; step();
    key_down = 4'b0001; step();
    chk("pause pre hit", int'(hit_pulse), 1);
    run = 1'b0; step();
    chk("pause hit", int'(hit_pulse), 0);
    chk("pause score", int'(score), 20);
    chk("pause combo", int'(combo), 1);
    key_down = 4'b0000; step();
    key_down = 4'b0001; step();
    chk("pause press hit", int'(hit_pulse), 0);
    chk("pause press miss", int'(miss_pulse), 0);
    run = 1'b1; in_zone = '0; key_down = '0; step(); step();
    chk("resume score", int'(score), 20);

    // Reset while a hit pulse is pending discards it.
    in_zone = 4'b0001; step();
    key_down = 4'b0001; step();
    chk("midrst pre hit", int'(hit_pulse), 1);
    reset = 1'b1; in_zone = '0; key_down = '0; step();
    chk("midrst hit", int'(hit_pulse), 0);
    step();
    chk("midrst score", int'(score), 0);
    chk("midrst combo", int'(combo), 0);
    reset = 1'b0; step();

    // Key held through reset and the run rise must not count as a press.
    reset = 1'b1; run = 1'b0; key_down = 4'b0010; step(); step();
    reset = 1'b0; step(); step();
    run = 1'b1; step();
    in_zone = 4'b0010; step();
    chk("held hit0", int'(hit_pulse), 0);
    step();
    chk("held hit1", int'(hit_pulse), 0);
    in_zone = 4'b0000; step();
    chk("held miss", int'(miss_pulse), 2);
    chk("held hit2", int'(hit_pulse), 0);
    key_down = '0; step();
    chk("held score", int'(score), 0);
    chk("held combo", int'(combo), 0);

    // Nine lane-1 hits: multiplier 2 after the eighth.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      do_hit(1);
      chk($sformatf("seq%0d score", i), int'(score), 10 * i);
    end
    chk("seq8 combo", int'(combo), 8);
    chk("seq8 mult", int'(multiplier), 2);
    do_hit(1);
    chk("seq9 score", int'(score), 100);
    chk("seq9 combo", int'(combo), 9);

    // Lanes 0,3 hit while lane 1 misses in the same cycle.
    do_reset();
    for (int i = 0; i < 5; i++) do_hit(0);
    chk("mix pre score", int'(score), 50);
    chk("mix pre combo", int'(combo), 5);
    chk("mix pre mult", int'(multiplier), 1);
    in_zone = 4'b1011; step();
    in_zone = 4'b1001; key_down = 4'b1001; step();
    chk("mix hit", int'(hit_pulse), 9);
    chk("mix miss", int'(miss_pulse), 2);
    in_zone = '0; key_down = '0; step();
    chk("mix score", int'(score), 70);
    chk("mix combo", int'(combo), 0);

    // Four-lane hit rounds until score and combo both saturate.
    do_reset();
    exp_s = 0; exp_c = 0;
    for (int r = 0; r < 450; r++) begin
      in_zone = 4'b1111; step();
      key_down = 4'b1111; step();
      in_zone = '0; key_down = '0; step();
      exp_m = (exp_c >= 24) ? 4 : 1 + exp_c / 8;
      exp_s = exp_s + 40 * exp_m;
      if (exp_s > 65535) exp_s = 65535;
      exp_c = exp_c + 4;
      if (exp_c > 255) exp_c = 255;
      chk($sformatf("sat%0d score", r), int'(score), exp_s);
      chk($sformatf("sat%0d combo", r), int'(combo), exp_c);
    end
    chk("sat final score", int'(score), 65535);
    chk("sat final combo", int'(combo), 255);
    chk("sat final mult", int'(multiplier), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
